// File: rtl/qwac_pkg.sv
// Shared QWAC host-link definitions: frame header, transmit FSM states and the
// default UART bit period (100 MHz / 115200 baud).
package qwac_pkg;

    localparam logic [7:0] QWAC_TX_HDR = 8'hA5;
    localparam int QWAC_TX_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } qwac_tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter: accepts a byte on a one-cycle valid while idle and
// pulses ready during the final clock of the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;

    // Bit 0 is the start bit, 1..8 data, 9 the stop bit; shreg holds {stop, data}.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
            tx      <= 1'b1;
        end else if (!active) begin
            if (valid) begin
                active  <= 1'b1;
                clk_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= {1'b1, data};
                tx      <= 1'b0;
            end
        end else if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            clk_cnt <= clk_cnt + CW'(1);
        end
    end

    assign ready = active && (clk_cnt == CLK_LAST) && (bit_cnt == 4'd9);

endmodule

// File: rtl/qwac_result_tx.sv
// Snapshots the matVec result array on start and streams it to the host as
// header, MSB-first element bytes and (with QWAC_TX_CHECKSUM_EN) a checksum byte.
module qwac_result_tx
    import qwac_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int MAT_R        = 8,
    parameter int TE           = 2,
    parameter int CLKS_PER_BIT = QWAC_TX_CLKS_PER_BIT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TE*MAT_R*BITS-1:0]  out_vecs,
    output logic                      busy,
    output logic                      done,
    output logic                      tx
);

    localparam int BPE     = BITS / 8;
    localparam int PAYLOAD = TE * MAT_R * BPE;
`ifdef QWAC_TX_CHECKSUM_EN
    localparam int TOTAL   = PAYLOAD + 2;
`else
    localparam int TOTAL   = PAYLOAD + 1;
`endif
    localparam int IW      = $clog2(TOTAL + 1);
    localparam int VW      = TE * MAT_R * BITS;
    localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
    localparam logic [IW-1:0] PAY_IDX  = IW'(PAYLOAD);

    qwac_tx_state_t state, state_next;
    logic [VW-1:0]  snap;
    logic [IW-1:0]  idx;
    logic [7:0]     cur_byte;
    logic           byte_valid;
    logic           byte_ready;
    logic [VW-1:0]  shifted;
    int             k;
    int             pos;
`ifdef QWAC_TX_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            snap  <= '0;
            idx   <= '0;
`ifdef QWAC_TX_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == LOAD) begin
                snap <= out_vecs;
                idx  <= '0;
`ifdef QWAC_TX_CHECKSUM_EN
                csum <= '0;
`endif
            end else if (state == WAIT && byte_ready) begin
                idx <= idx + IW'(1);
`ifdef QWAC_TX_CHECKSUM_EN
                if (idx != '0 && idx <= PAY_IDX)
                    csum <= csum + cur_byte;
`endif
            end
        end
    end

    // Byte k of the payload is byte (k % BPE) of element (k / BPE), counted from the MSB.
    always_comb begin
        cur_byte = QWAC_TX_HDR;
        k        = 0;
        pos      = 0;
        shifted  = snap;
        if (idx == '0) begin
            cur_byte = QWAC_TX_HDR;
        end else if (idx <= PAY_IDX) begin
            k        = int'(idx) - 1;
            pos      = (k / BPE) * BITS + BITS - 8 - 8 * (k % BPE);
            shifted  = snap >> pos;
            cur_byte = shifted[7:0];
        end
`ifdef QWAC_TX_CHECKSUM_EN
        else begin
            cur_byte = csum;
        end
`endif
    end

    always_comb begin
        state_next = state;
        byte_valid = 1'b0;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: begin
                byte_valid = 1'b1;
                state_next = WAIT;
            end
            WAIT: if (byte_ready) state_next = (idx == LAST_IDX) ? DONE : SEND;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == LOAD) || (state == SEND) || (state == WAIT);
    assign done = (state == DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clock(clock),
        .reset(reset),
        .valid(byte_valid),
        .data (cur_byte),
        .tx   (tx),
        .ready(byte_ready)
    );

endmodule

// File: tb/tb_qwac_result_tx.sv
// Bench for qwac_result_tx: directed and random result arrays decoded by a UART
// receiver model and compared with a byte list built from the frame rules.
`timescale 1ns/1ps
module tb_qwac_result_tx;

    localparam int BITS   = 16;
    localparam int MAT_R  = 8;
    localparam int TE     = 2;
    localparam int CPB    = 4;
    localparam int VW     = TE * MAT_R * BITS;
    localparam int BPE    = BITS / 8;
    localparam int BUDGET = 5000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] out_vecs = '0;
    logic          busy, done, tx;

    int n_cmp = 0;
    int n_err = 0;

    logic [BITS-1:0] m [TE][MAT_R];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int done_cnt = 0;
    int rx_ferr  = 0;

    qwac_result_tx #(
        .BITS(BITS), .MAT_R(MAT_R), .TE(TE), .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .out_vecs(out_vecs), .busy(busy), .done(done), .tx(tx)
    );

    // clock / reset
    always #5 clock = ~clock;

    // UART receiver model: samples each bit near its middle on the falling edge.
    logic       rx_active = 1'b0;
    int         rx_c = 0;
    logic [7:0] rx_sh = '0;
    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            rx_active <= 1'b0;
            rx_c      <= 0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active <= 1'b1;
                rx_c      <= 1;
            end
        end else begin
            rx_c <= rx_c + 1;
            if (rx_c % CPB == CPB / 2 && rx_c / CPB >= 1 && rx_c / CPB <= 8)
                rx_sh <= {tx, rx_sh[7:1]};
            if (rx_c == 9 * CPB + CPB / 2) begin
                if (tx !== 1'b1) rx_ferr <= rx_ferr + 1;
                rx_q.push_back(rx_sh);
                rx_active <= 1'b0;
            end
        end
    end

    always @(negedge clock) if (reset && done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic apply_model();
        for (int t = 0; t < TE; t++)
            for (int r = 0; r < MAT_R; r++)
                out_vecs[(t*MAT_R+r)*BITS +: BITS] = m[t][r];
    endtask

    task automatic build_exp();
        int sum;
        logic [BITS-1:0] v;
        sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int t = 0; t < TE; t++)
            for (int r = 0; r < MAT_R; r++) begin
                v = m[t][r];
                for (int b = BPE - 1; b >= 0; b--) begin
                    exp_q.push_back(8'((v >> (8 * b)) & 'hFF));
                    sum += int'((v >> (8 * b)) & 'hFF);
                end
            end
`ifdef QWAC_TX_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c0, n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        if (n >= BUDGET) check({tag, "_timeout"}, 32'(n), 32'(0));
        repeat (4) @(negedge clock);
    endtask

    task automatic compare_frame(input string tag, input int d0);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'(1));
        check({tag, "_busy_end"}, 32'(busy), 32'(0));
    endtask

    task automatic run_frame(input string tag);
        int d0;
        apply_model();
        build_exp();
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(tag);
        compare_frame(tag, d0);
    endtask

    // stimulus and scoreboard
    initial begin
        int d0;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);

        // Ones matrix times ones vector; also checks start-to-line latency.
        foreach (m[t, r]) m[t][r] = 16'h0004;
        apply_model();
        build_exp();
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        check("lat_busy", 32'(busy), 32'(1));
        check("lat_tx0", 32'(tx), 32'(1));
        @(negedge clock);
        check("lat_tx1", 32'(tx), 32'(1));
        @(negedge clock);
        check("lat_tx2", 32'(tx), 32'(0));
        wait_done("ones");
        compare_frame("ones", d0);
        check("ones_ferr", 32'(rx_ferr), 32'(0));

        // Byte order and sign.
        foreach (m[t, r]) m[t][r] = (t == 0) ? 16'h0008 : 16'hFFF0;
        run_frame("sign");

        // Random arrays.
        for (int it = 0; it < 2; it++) begin
            foreach (m[t, r]) m[t][r] = 16'($urandom_range(0, 65535));
            run_frame($sformatf("rand%0d", it));
        end

        // Input changes after the snapshot must not reach the frame.
        foreach (m[t, r]) m[t][r] = 16'($urandom);
        apply_model();
        build_exp();
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        @(negedge clock);
        out_vecs = {(TE*MAT_R){16'h1234}};
        wait_done("snap");
        compare_frame("snap", d0);

        // Extra start while busy is ignored.
        foreach (m[t, r]) m[t][r] = 16'($urandom);
        apply_model();
        build_exp();
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        repeat ($urandom_range(20, 200)) @(negedge clock);
        pulse_start();
        wait_done("rebusy");
        repeat (30 * CPB) @(negedge clock);
        compare_frame("rebusy", d0);

        // Reset during byte 5, then a clean frame.
        foreach (m[t, r]) m[t][r] = 16'($urandom);
        apply_model();
        rx_q.delete();
        d0 = done_cnt;
        pulse_start();
        begin
            int n = 0;
            while (rx_q.size() < 5 && n < BUDGET) begin
                @(negedge clock);
                n++;
            end
            check("mrst_wait", 32'(rx_q.size()), 32'(5));
        end
        repeat (5 * CPB) @(negedge clock);
        reset = 1'b0;
        #1;
        check("mrst_tx", 32'(tx), 32'(1));
        check("mrst_busy", 32'(busy), 32'(0));
        repeat (30 * CPB) @(negedge clock);
        check("mrst_tx_hold", 32'(tx), 32'(1));
        check("mrst_nobyte", 32'(rx_q.size()), 32'(5));
        check("mrst_nodone", 32'(done_cnt - d0), 32'(0));
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);
        foreach (m[t, r]) m[t][r] = 16'($urandom);
        run_frame("post");
        check("final_ferr", 32'(rx_ferr), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
